// File: rtl/add_pipe_pkg.sv
// Shared widths and operand-entry layout for the add pipeline stage.
// Optional subtraction is enabled by defining ADD_PIPE_SUB_EN.
package add_pipe_pkg;

   localparam int unsigned DATA_W             = 32;
   localparam int unsigned FIFO_DEPTH_DEFAULT = 2;

   typedef struct packed {
      logic              sub;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } operand_t;

   localparam int unsigned OP_W = $bits(operand_t);

endpackage

// File: rtl/add_pipe_fifo.sv
// Circular operand buffer; caller guarantees no push when full and no pop when empty.
module add_pipe_fifo
   import add_pipe_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic [OP_W-1:0] wdata,
   input  logic            pop,
   output logic [OP_W-1:0] rdata,
   output logic            empty,
   output logic            full
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [OP_W-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign rdata = mem_q[rd_ptr_q];

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/add_pipe_stage.sv
// Buffered operand stage feeding an external 32-bit adder, with a registered result.
// Define ADD_PIPE_SUB_EN to honour in_sub (a - b via two's-complement negation of b).
module add_pipe_stage
   import add_pipe_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_sub,
   output logic [DATA_W-1:0] add_in1,
   output logic [DATA_W-1:0] add_in2,
   input  logic [DATA_W-1:0] add_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   operand_t        wr_op, head;
   logic [OP_W-1:0] head_raw;
   logic            push, pop, empty, full;
   logic            out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;

   assign in_ready = !full;
   assign push     = in_valid & in_ready;
   assign pop      = !empty & (!out_valid_q | out_ready);

   always_comb begin
      wr_op   = '0;
      wr_op.a = in_a;
      wr_op.b = in_b;
`ifdef ADD_PIPE_SUB_EN
      wr_op.sub = in_sub;
`endif
   end

   add_pipe_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (wr_op),
      .pop   (pop),
      .rdata (head_raw),
      .empty (empty),
      .full  (full)
   );

   assign head = operand_t'(head_raw);

   always_comb begin
      add_in1 = '0;
      add_in2 = '0;
      if (!empty) begin
         add_in1 = head.a;
`ifdef ADD_PIPE_SUB_EN
         add_in2 = head.sub ? (~head.b + DATA_W'(1)) : head.b;
`else
         add_in2 = head.b;
`endif
      end
   end

`ifndef ADD_PIPE_SUB_EN
   logic unused_sub;
   assign unused_sub = in_sub ^ head.sub;
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (pop) begin
         out_valid_d = 1'b1;
         out_data_d  = add_out;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule
